// File: rtl/fifo_bank_scheduler.sv
// fifo_bank_scheduler: ping-pong bank scheduler between the BLVDS frame receiver and the uPP reader
// Ports: iCLK/iRST_N (async active-low); iFRAME_DONE/iFRAME_ABORT from the receiver;
//   iRD_DONE/iRD_EMPTY from the reader; oSEL_CH_WR/oSEL_CH_RD bank selects; oACLR per-bank clear;
//   oRD_START, oWR_STALL, oRD_TIMEOUT status pulses/levels; oBANK_STATE {bank1,bank0};
//   oFRAME_CNT/oDROP_CNT statistics, present only when ARB_STATS_EN is defined (otherwise tied to 0).
module fifo_bank_scheduler #(
  parameter logic [3:0]  SETTLE_CYC = 4'd4,
  parameter logic [3:0]  ACLR_CYC   = 4'd3,
  parameter logic [15:0] DRAIN_TMO  = 16'd5000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iFRAME_DONE,
  input  logic        iFRAME_ABORT,
  input  logic        iRD_DONE,
  input  logic        iRD_EMPTY,
  output logic        oSEL_CH_WR,
  output logic        oSEL_CH_RD,
  output logic [1:0]  oACLR,
  output logic        oRD_START,
  output logic        oWR_STALL,
  output logic [3:0]  oBANK_STATE,
  output logic        oRD_TIMEOUT,
  output logic [15:0] oFRAME_CNT,
  output logic [15:0] oDROP_CNT
);
  localparam logic [1:0] FREE = 2'd0, FILL = 2'd1, READY = 2'd2, DRAIN = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT, S_CLEAR} rd_t;
  rd_t rd_state_q, rd_state_d;
  logic [1:0][1:0] bank_q, bank_d;
  logic [1:0][3:0] aclr_q, aclr_d;
  logic [15:0] cnt_q, cnt_d;
  logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, stall_q, stall_d, age_q, age_d;
  logic rd_start_q, rd_start_d, tmo_q, tmo_d;
  logic any_ready, pick, wr_done, wr_abort, wr_switch;
  // age_q remembers which bank turned READY first, so the reader drains oldest-first
  always_comb begin
    any_ready = bank_q[0] == READY || bank_q[1] == READY;
    pick = (bank_q[0] == READY && bank_q[1] == READY) ? age_q : bank_q[1] == READY;
    wr_done = iFRAME_DONE && !iFRAME_ABORT && !stall_q;
    wr_abort = iFRAME_ABORT && !stall_q;
    wr_switch = (wr_done || stall_q) && bank_q[~wr_sel_q] == FREE;
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      rd_state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      cnt_q <= cnt_d;
    end
  // cnt_q counts cycles spent in the current read state (settle delay and drain timeout)
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      S_IDLE:   rd_state_d = any_ready ? S_SETTLE : S_IDLE;
      S_SETTLE: rd_state_d = cnt_q == 16'(SETTLE_CYC) - 16'd1 ? S_WAIT : S_SETTLE;
      S_WAIT:   rd_state_d = iRD_DONE ? (iRD_EMPTY ? S_IDLE : S_CLEAR) : (cnt_q == DRAIN_TMO - 16'd1 ? S_CLEAR : S_WAIT);
      default:  rd_state_d = aclr_q[rd_sel_q] == 4'd1 ? S_IDLE : S_CLEAR;
    endcase
    cnt_d = rd_state_d != rd_state_q ? '0 : cnt_q + 16'd1;
  end
  always_comb begin
    rd_start_d = rd_state_q == S_SETTLE && rd_state_d == S_WAIT;
    tmo_d = rd_state_q == S_WAIT && rd_state_d == S_CLEAR && !iRD_DONE;
  end
  // write side only touches FILL/FREE banks, read side only READY/DRAIN banks, so they never collide
  always_comb begin
    bank_d = bank_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    age_d = age_q;
    for (int n = 0; n < 2; n++) aclr_d[n] = aclr_q[n] != 4'd0 ? aclr_q[n] - 4'd1 : 4'd0;
    if (wr_done) begin
      bank_d[wr_sel_q] = READY;
      if (bank_q[~wr_sel_q] != READY) age_d = wr_sel_q;
    end
    if (wr_switch) begin
      bank_d[~wr_sel_q] = FILL;
      wr_sel_d = ~wr_sel_q;
    end
    stall_d = (wr_done || stall_q) && !wr_switch;
    if (wr_abort) aclr_d[wr_sel_q] = ACLR_CYC;
    if (rd_state_q == S_IDLE && any_ready) begin
      rd_sel_d = pick;
      bank_d[pick] = DRAIN;
    end
    if (rd_state_q == S_WAIT && rd_state_d == S_CLEAR) aclr_d[rd_sel_q] = ACLR_CYC;
    if ((rd_state_q == S_WAIT || rd_state_q == S_CLEAR) && rd_state_d == S_IDLE) bank_d[rd_sel_q] = FREE;
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      bank_q <= {FREE, FILL};
      aclr_q <= {ACLR_CYC, ACLR_CYC};
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      stall_q <= 1'b0;
      age_q <= 1'b0;
      rd_start_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      aclr_q <= aclr_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      stall_q <= stall_d;
      age_q <= age_d;
      rd_start_q <= rd_start_d;
      tmo_q <= tmo_d;
    end
  assign oSEL_CH_WR = wr_sel_q;
  assign oSEL_CH_RD = rd_sel_q;
  assign oACLR = {|aclr_q[1], |aclr_q[0]};
  assign oRD_START = rd_start_q;
  assign oWR_STALL = stall_q;
  assign oBANK_STATE = bank_q;
  assign oRD_TIMEOUT = tmo_q;
`ifdef ARB_STATS_EN
  logic [15:0] frame_q, frame_d, drop_q, drop_d;
  logic [16:0] drop_sum;
  // abort/overrun and a read-side clear can land in the same cycle, so up to two drops per cycle
  always_comb begin
    drop_sum = {1'b0, drop_q}
      + 17'((iFRAME_ABORT && !stall_q) || (iFRAME_DONE && !iFRAME_ABORT && stall_q))
      + 17'(rd_state_q == S_WAIT && rd_state_d == S_CLEAR);
    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    frame_d = rd_start_d && frame_q != 16'hFFFF ? frame_q + 16'd1 : frame_q;
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      frame_q <= '0;
      drop_q <= '0;
    end else begin
      frame_q <= frame_d;
      drop_q <= drop_d;
    end
  assign oFRAME_CNT = frame_q;
  assign oDROP_CNT = drop_q;
`else
  assign oFRAME_CNT = '0;
  assign oDROP_CNT = '0;
`endif
endmodule

// File: tb/tb_fifo_bank_scheduler.sv
// tb_fifo_bank_scheduler: randomized bench against a queue/timestamp reference model of the scheduler
module tb_fifo_bank_scheduler;
  localparam int FREE = 0, FILL = 1, READY = 2, DRAIN = 3;
  localparam int SETTLE = 4, ACLR = 3, TMO = 5000;
  logic iCLK = 0, iRST_N = 1, iFRAME_DONE = 0, iFRAME_ABORT = 0, iRD_DONE = 0, iRD_EMPTY = 0;
  logic oSEL_CH_WR, oSEL_CH_RD, oRD_START, oWR_STALL, oRD_TIMEOUT;
  logic [1:0] oACLR;
  logic [3:0] oBANK_STATE;
  logic [15:0] oFRAME_CNT, oDROP_CNT;
  int errors = 0, checks = 0;
  fifo_bank_scheduler dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFRAME_DONE(iFRAME_DONE), .iFRAME_ABORT(iFRAME_ABORT),
    .iRD_DONE(iRD_DONE), .iRD_EMPTY(iRD_EMPTY), .oSEL_CH_WR(oSEL_CH_WR), .oSEL_CH_RD(oSEL_CH_RD),
    .oACLR(oACLR), .oRD_START(oRD_START), .oWR_STALL(oWR_STALL), .oBANK_STATE(oBANK_STATE),
    .oRD_TIMEOUT(oRD_TIMEOUT), .oFRAME_CNT(oFRAME_CNT), .oDROP_CNT(oDROP_CNT)
  );
  always #5 iCLK = ~iCLK;
  // reference model: banks, a FIFO of ready banks, and absolute edge timestamps for the reader
  int m_bank[2];
  int aclr_until[2];
  int rdyq[$];
  int m_wr, m_rd, m_stall, m_phase, t_sel, t_start, t_clr, e, frames, drops, exp_start, exp_tmo;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, e);
    end
  endtask
  task automatic model_reset();
    m_bank[0] = FILL;
    m_bank[1] = FREE;
    aclr_until[0] = ACLR;
    aclr_until[1] = ACLR;
    rdyq.delete();
    m_wr = 0; m_rd = 0; m_stall = 0; m_phase = 0; e = 0;
    frames = 0; drops = 0; exp_start = 0; exp_tmo = 0;
  endtask
  task automatic enter_clear();
    t_clr = e;
    aclr_until[m_rd] = e + ACLR;
    drops++;
    m_phase = 3;
  endtask
  task automatic model_step(input bit done, input bit abort, input bit rdd, input bit empty);
    int old[2];
    old = m_bank;
    e++;
    exp_start = 0;
    exp_tmo = 0;
    case (m_phase)
      0: if (rdyq.size() > 0) begin
        m_rd = rdyq.pop_front();
        m_bank[m_rd] = DRAIN;
        t_sel = e;
        m_phase = 1;
      end
      1: if (e == t_sel + SETTLE) begin
        exp_start = 1;
        frames++;
        t_start = e;
        m_phase = 2;
      end
      2: if (rdd) begin
        if (empty) begin
          m_bank[m_rd] = FREE;
          m_phase = 0;
        end else enter_clear();
      end else if (e == t_start + TMO) begin
        exp_tmo = 1;
        enter_clear();
      end
      default: if (e == t_clr + ACLR) begin
        m_bank[m_rd] = FREE;
        m_phase = 0;
      end
    endcase
    if (!m_stall) begin
      if (abort) begin
        aclr_until[m_wr] = e + ACLR;
        drops++;
      end else if (done) begin
        m_bank[m_wr] = READY;
        rdyq.push_back(m_wr);
        if (old[1 - m_wr] == FREE) begin
          m_bank[1 - m_wr] = FILL;
          m_wr = 1 - m_wr;
        end else m_stall = 1;
      end
    end else begin
      if (done && !abort) drops++;
      if (old[1 - m_wr] == FREE) begin
        m_bank[1 - m_wr] = FILL;
        m_wr = 1 - m_wr;
        m_stall = 0;
      end
    end
  endtask
  task automatic compare();
    check("bank_state", 32'(oBANK_STATE), m_bank[1] * 4 + m_bank[0]);
    check("sel_wr", 32'(oSEL_CH_WR), m_wr);
    check("sel_rd", 32'(oSEL_CH_RD), m_rd);
    check("aclr", 32'(oACLR), (e < aclr_until[1] ? 2 : 0) + (e < aclr_until[0] ? 1 : 0));
    check("rd_start", 32'(oRD_START), exp_start);
    check("wr_stall", 32'(oWR_STALL), m_stall);
    check("rd_timeout", 32'(oRD_TIMEOUT), exp_tmo);
`ifdef ARB_STATS_EN
    check("frame_cnt", 32'(oFRAME_CNT), frames);
    check("drop_cnt", 32'(oDROP_CNT), drops);
`else
    check("frame_cnt", 32'(oFRAME_CNT), 0);
    check("drop_cnt", 32'(oDROP_CNT), 0);
`endif
  endtask
  // probabilities are per mille; abort is withheld while stalled since the receiver is idle then
  task automatic run(input int n, input int pd, input int pa, input int pr, input int pe);
    for (int i = 0; i < n; i++) begin
      iFRAME_DONE = $urandom_range(999) < pd;
      iFRAME_ABORT = !m_stall && $urandom_range(999) < pa;
      iRD_DONE = $urandom_range(999) < pr;
      iRD_EMPTY = $urandom_range(999) < pe;
      @(posedge iCLK);
      model_step(iFRAME_DONE, iFRAME_ABORT, iRD_DONE, iRD_EMPTY);
      #1 compare();
      @(negedge iCLK);
    end
  endtask
  task automatic mid_reset();
    #2 iRST_N = 0;
    iFRAME_DONE = 0; iFRAME_ABORT = 0; iRD_DONE = 0; iRD_EMPTY = 0;
    model_reset();
    #1 compare();
    repeat (2) @(posedge iCLK);
    #1 compare();
    @(negedge iCLK);
    iRST_N = 1;
    #1 compare();
  endtask
  initial begin
    model_reset();
    #2 iRST_N = 0;
    #1 compare();
    repeat (2) @(negedge iCLK);
    iRST_N = 1;
    #1 compare();
    run(3000, 60, 10, 150, 800);
    run(6000, 50, 5, 0, 1000);
    run(2000, 100, 20, 300, 500);
    mid_reset();
    run(2000, 80, 15, 200, 700);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
